// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Two-requester arbiter in front of the single-port data memory.
//   Requester 0 is the CPU MEM stage, requester 1 a secondary master
//   (debug loader / DMA). At most one access is granted per cycle. The
//   winner's address, write data, byte enables and PC are steered to the
//   memory, and the memory's read word is registered back to the winner
//   together with a one-cycle ack pulse.
//
//   Parameters
//     ROUND_ROBIN   1: alternate on conflict, 0: requester 0 always wins
//     STARVE_LIMIT  denied-cycle count that forces a win (1..255, 0 = off)
//
//   Ports
//     clk, reset              clock, synchronous active-high reset
//     mX_req/addr/wdata/we/pc request side of requester X (X = 0, 1)
//     mX_lock                 bus lock request (only with DM_ARB_LOCK_EN)
//     mX_gnt                  access accepted this cycle (combinational)
//     mX_ack, mX_rdata        completion pulse and read word, one cycle later
//     dm_addr/wdata/we/pc     to the memory
//     dm_rdata                from the memory (combinational on dm_addr)
//
//   Optional feature macro: DM_ARB_LOCK_EN (bus lock). Without it the lock
//   inputs are ignored and no requester ever owns the lock.

module dm_arbiter #(
   parameter int unsigned ROUND_ROBIN  = 1,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        m0_req,
   input  logic [29:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_we,
   input  logic [31:0] m0_pc,
   input  logic        m0_lock,
   output logic        m0_gnt,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic [29:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_we,
   input  logic [31:0] m1_pc,
   input  logic        m1_lock,
   output logic        m1_gnt,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,

   output logic [29:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_we,
   output logic [31:0] dm_pc,
   input  logic [31:0] dm_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } lock_owner_e;

   localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);
   localparam bit         FORCE_EN = (STARVE_LIMIT != 0);
   localparam bit         RR_EN    = (ROUND_ROBIN != 0);

   // State
   logic [7:0]  starve0_q, starve0_d;
   logic [7:0]  starve1_q, starve1_d;
   logic        last_gnt_q, last_gnt_d;   // 1 = requester 1 won last
   lock_owner_e lock_owner_q, lock_owner_d;
   logic        m0_ack_q, m0_ack_d;
   logic        m1_ack_q, m1_ack_d;
   logic [31:0] m0_rdata_q, m0_rdata_d;
   logic [31:0] m1_rdata_q, m1_rdata_d;

   // Arbitration terms
   logic lock0_act, lock1_act;
   logic force0, force1;
   logic win0, win1;

   // Arbitration: lock owner, then starved requester (0 before 1), then a
   // lone requester, then round-robin / fixed priority on conflict.
   always_comb begin
      lock0_act = (lock_owner_q == OWN_M0) && m0_req && m0_lock;
      lock1_act = (lock_owner_q == OWN_M1) && m1_req && m1_lock;
      force0    = FORCE_EN && m0_req && (starve0_q >= LIMIT);
      force1    = FORCE_EN && m1_req && (starve1_q >= LIMIT);

      win0 = 1'b0;
      win1 = 1'b0;
      if (!reset) begin
         if (lock0_act) begin
            win0 = 1'b1;
         end else if (lock1_act) begin
            win1 = 1'b1;
         end else if (force0) begin
            win0 = 1'b1;
         end else if (force1) begin
            win1 = 1'b1;
         end else if (m0_req && m1_req) begin
            if (RR_EN && !last_gnt_q) begin
               win1 = 1'b1;
            end else begin
               win0 = 1'b1;
            end
         end else if (m0_req) begin
            win0 = 1'b1;
         end else if (m1_req) begin
            win1 = 1'b1;
         end
      end
   end

   // Memory-side mux; everything is zero when nobody wins (incl. reset)
   always_comb begin
      dm_addr  = '0;
      dm_wdata = '0;
      dm_we    = '0;
      dm_pc    = '0;
      if (win0) begin
         dm_addr  = m0_addr;
         dm_wdata = m0_wdata;
         dm_we    = m0_we;
         dm_pc    = m0_pc;
      end else if (win1) begin
         dm_addr  = m1_addr;
         dm_wdata = m1_wdata;
         dm_we    = m1_we;
         dm_pc    = m1_pc;
      end
   end

   // Next-state
   always_comb begin
      // Starvation counters: count consecutive denied cycles, saturating
      if (!m0_req || win0) begin
         starve0_d = '0;
      end else if (starve0_q == 8'hFF) begin
         starve0_d = starve0_q;
      end else begin
         starve0_d = starve0_q + 8'd1;
      end

      if (!m1_req || win1) begin
         starve1_d = '0;
      end else if (starve1_q == 8'hFF) begin
         starve1_d = starve1_q;
      end else begin
         starve1_d = starve1_q + 8'd1;
      end

      last_gnt_d = last_gnt_q;
      if (win0) begin
         last_gnt_d = 1'b0;
      end else if (win1) begin
         last_gnt_d = 1'b1;
      end

`ifdef DM_ARB_LOCK_EN
      // Ownership follows every grant taken with lock set and lapses as
      // soon as the owner is not granted with lock (lock or req dropped).
      lock_owner_d = OWN_NONE;
      if (win0 && m0_lock) begin
         lock_owner_d = OWN_M0;
      end else if (win1 && m1_lock) begin
         lock_owner_d = OWN_M1;
      end
`else
      lock_owner_d = OWN_NONE;
`endif

      m0_ack_d   = win0;
      m1_ack_d   = win1;
      m0_rdata_d = win0 ? dm_rdata : m0_rdata_q;
      m1_rdata_d = win1 ? dm_rdata : m1_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve0_q    <= '0;
         starve1_q    <= '0;
         last_gnt_q   <= 1'b1;
         lock_owner_q <= OWN_NONE;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         starve0_q    <= starve0_d;
         starve1_q    <= starve1_d;
         last_gnt_q   <= last_gnt_d;
         lock_owner_q <= lock_owner_d;
         m0_ack_q     <= m0_ack_d;
         m1_ack_q     <= m1_ack_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign m0_gnt   = win0;
   assign m1_gnt   = win1;
   // An ack already registered when reset rises is suppressed at once
   assign m0_ack   = m0_ack_q & ~reset;
   assign m1_ack   = m1_ack_q & ~reset;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Drives two arbiter instances: instance 0 with ROUND_ROBIN=1,
//   STARVE_LIMIT=8 and instance 1 with ROUND_ROBIN=0, STARVE_LIMIT=3, each
//   with its own 64-word memory. Directed scenarios are followed by random
//   traffic; every cycle is compared against a behavioural reference model.

module tb_dm_arbiter;

`ifdef DM_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  i_req  [2];
   logic [1:0]  i_lock [2];
   logic [29:0] i_addr [2][2];
   logic [31:0] i_wd   [2][2];
   logic [3:0]  i_we   [2][2];
   logic [31:0] i_pc   [2][2];

   logic [1:0]  o_gnt  [2];
   logic [1:0]  o_ack  [2];
   logic [31:0] o_rd   [2][2];
   logic [29:0] o_addr [2];
   logic [31:0] o_wd   [2];
   logic [3:0]  o_we   [2];
   logic [31:0] o_pc   [2];
   logic [31:0] mem    [2][64];

   for (genvar g = 0; g < 2; g++) begin : gd
      logic        g0, g1, a0, a1;
      logic [31:0] r0, r1, wd, pc, rd;
      logic [29:0] ad;
      logic [3:0]  we;

      assign rd = mem[g][o_addr[g][5:0]];

      dm_arbiter #(
         .ROUND_ROBIN  (g == 0 ? 1 : 0),
         .STARVE_LIMIT (g == 0 ? 8 : 3)
      ) dut (
         .clk      (clk),
         .reset    (rst),
         .m0_req   (i_req[g][0]),
         .m0_addr  (i_addr[g][0]),
         .m0_wdata (i_wd[g][0]),
         .m0_we    (i_we[g][0]),
         .m0_pc    (i_pc[g][0]),
         .m0_lock  (i_lock[g][0]),
         .m0_gnt   (g0),
         .m0_ack   (a0),
         .m0_rdata (r0),
         .m1_req   (i_req[g][1]),
         .m1_addr  (i_addr[g][1]),
         .m1_wdata (i_wd[g][1]),
         .m1_we    (i_we[g][1]),
         .m1_pc    (i_pc[g][1]),
         .m1_lock  (i_lock[g][1]),
         .m1_gnt   (g1),
         .m1_ack   (a1),
         .m1_rdata (r1),
         .dm_addr  (ad),
         .dm_wdata (wd),
         .dm_we    (we),
         .dm_pc    (pc),
         .dm_rdata (rd)
      );

      assign o_gnt[g]   = {g1, g0};
      assign o_ack[g]   = {a1, a0};
      assign o_rd[g][0] = r0;
      assign o_rd[g][1] = r1;
      assign o_addr[g]  = ad;
      assign o_wd[g]    = wd;
      assign o_we[g]    = we;
      assign o_pc[g]    = pc;
   end

   // Reference model state
   int          cnt    [2][2];
   int          last   [2];     // requester that won most recently
   int          owner  [2];     // -1 = no lock owner
   bit          ack_st [2][2];
   logic [31:0] rd_st  [2][2];
   int          win    [2];     // model winner of the last cycle

   // Samples of the last cycle for directed checks
   logic [1:0]  s_gnt [2];
   logic [1:0]  s_ack [2];
   logic [31:0] s_rd  [2][2];
   logic [3:0]  s_we  [2];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic int limit_of(input int d);
      return (d == 0) ? 8 : 3;
   endfunction

   function automatic bit rr_of(input int d);
      return d == 0;
   endfunction

   // Who should win this cycle, from the arbitration rules
   function automatic int pick(input int d);
      if (rst) return -1;
      if (LOCK_EN && owner[d] >= 0 && i_req[d][owner[d]] && i_lock[d][owner[d]])
         return owner[d];
      for (int x = 0; x < 2; x++)
         if (i_req[d][x] && cnt[d][x] >= limit_of(d)) return x;
      if (i_req[d] == 2'b01) return 0;
      if (i_req[d] == 2'b10) return 1;
      if (i_req[d] == 2'b11) return rr_of(d) ? 1 - last[d] : 0;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         last[d]  = 1;
         owner[d] = -1;
         for (int x = 0; x < 2; x++) begin
            cnt[d][x]    = 0;
            ack_st[d][x] = 1'b0;
            rd_st[d][x]  = '0;
         end
      end
   endtask

   // One clock cycle: check settled outputs, then clock, then update the
   // memory and the model.
   task automatic cycle();
      logic [29:0] wa [2];
      logic [31:0] wdv [2];
      logic [3:0]  wev [2];
      int          w;
      #3;
      for (int d = 0; d < 2; d++) begin
         w = pick(d);
         win[d] = w;
         s_gnt[d] = o_gnt[d];
         s_ack[d] = o_ack[d];
         s_we[d]  = o_we[d];
         for (int x = 0; x < 2; x++) begin
            s_rd[d][x] = o_rd[d][x];
            chk($sformatf("d%0d.gnt%0d", d, x), 32'(o_gnt[d][x]), 32'(w == x));
            chk($sformatf("d%0d.ack%0d", d, x), 32'(o_ack[d][x]), 32'(ack_st[d][x] && !rst));
            if (ack_st[d][x] && !rst)
               chk($sformatf("d%0d.rdata%0d", d, x), o_rd[d][x], rd_st[d][x]);
         end
         chk($sformatf("d%0d.dm_addr", d),  32'(o_addr[d]), (w >= 0) ? 32'(i_addr[d][w]) : 32'd0);
         chk($sformatf("d%0d.dm_wdata", d), o_wd[d], (w >= 0) ? i_wd[d][w] : 32'd0);
         chk($sformatf("d%0d.dm_pc", d),    o_pc[d], (w >= 0) ? i_pc[d][w] : 32'd0);
         chk($sformatf("d%0d.dm_we", d),    32'(o_we[d]), (w >= 0) ? 32'(i_we[d][w]) : 32'd0);
         wa[d]  = o_addr[d];
         wdv[d] = o_wd[d];
         wev[d] = o_we[d];
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            last[d]  = 1;
            owner[d] = -1;
            for (int x = 0; x < 2; x++) begin
               cnt[d][x]    = 0;
               ack_st[d][x] = 1'b0;
               rd_st[d][x]  = '0;
            end
         end else begin
            for (int x = 0; x < 2; x++) begin
               if (win[d] == x) begin
                  ack_st[d][x] = 1'b1;
                  rd_st[d][x]  = mem[d][i_addr[d][x][5:0]];
                  cnt[d][x]    = 0;
               end else begin
                  ack_st[d][x] = 1'b0;
                  cnt[d][x]    = i_req[d][x] ? ((cnt[d][x] < 255) ? cnt[d][x] + 1 : 255) : 0;
               end
            end
            if (win[d] >= 0) last[d] = win[d];
            owner[d] = (LOCK_EN && win[d] >= 0 && i_lock[d][win[d]]) ? win[d] : -1;
         end
         // The memory follows what the DUT actually drove
         for (int b = 0; b < 4; b++)
            if (wev[d][b]) mem[d][wa[d][5:0]][8*b +: 8] = wdv[d][8*b +: 8];
      end
   endtask

   task automatic set_req(input int d, input int x, input int a, input logic [31:0] wd,
                          input logic [3:0] we, input logic lk);
      i_req[d][x]  = 1'b1;
      i_addr[d][x] = 30'(a);
      i_wd[d][x]   = wd;
      i_we[d][x]   = we;
      i_pc[d][x]   = 32'h1000 + 32'(a * 4);
      i_lock[d][x] = lk;
   endtask

   task automatic rand_req(input int d, input int x);
      set_req(d, x, $urandom_range(0, 63), $urandom,
              ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0,
              $urandom_range(0, 3) == 0);
      i_pc[d][x] = $urandom;
   endtask

   task automatic idle();
      for (int d = 0; d < 2; d++) begin
         i_req[d]  = '0;
         i_lock[d] = '0;
         for (int x = 0; x < 2; x++) begin
            i_addr[d][x] = '0;
            i_wd[d][x]   = '0;
            i_we[d][x]   = '0;
            i_pc[d][x]   = '0;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 64; i++) mem[d][i] = $urandom;
      rst = 1'b1;
      idle();
      cycle();
      do_reset();
      for (int d = 0; d < 2; d++)
         for (int x = 0; x < 2; x++)
            chk($sformatf("reset.rdata d%0d m%0d", d, x), o_rd[d][x], 32'd0);

      // Single read
      mem[0][5] = 32'h12345678;
      set_req(0, 0, 5, 32'h0, 4'h0, 1'b0);
      cycle();
      chk("read.gnt0", 32'(s_gnt[0][0]), 32'd1);
      chk("read.gnt1", 32'(s_gnt[0][1]), 32'd0);
      idle();
      cycle();
      chk("read.ack0", 32'(s_ack[0][0]), 32'd1);
      chk("read.rdata0", s_rd[0][0], 32'h12345678);
      chk("read.ack1", 32'(s_ack[0][1]), 32'd0);

      // Round-robin conflict
      do_reset();
      set_req(0, 0, 10, 32'h0, 4'h0, 1'b0);
      set_req(0, 1, 20, 32'h0, 4'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk($sformatf("rr.gnt0 k%0d", k), 32'(s_gnt[0][0]), 32'(k % 2 == 0));
         chk($sformatf("rr.gnt1 k%0d", k), 32'(s_gnt[0][1]), 32'(k % 2 == 1));
         if (k > 0) chk($sformatf("rr.ack0 k%0d", k), 32'(s_ack[0][0]), 32'((k - 1) % 2 == 0));
         set_req(0, k % 2, 11 + k, 32'h0, 4'h0, 1'b0);
      end
      idle();
      cycle();
      chk("rr.ack1 tail", 32'(s_ack[0][1]), 32'd1);

      // Fixed priority with starvation forcing (instance 1)
      do_reset();
      set_req(1, 0, 1, 32'h0, 4'h0, 1'b0);
      set_req(1, 1, 2, 32'h0, 4'h0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         cycle();
         chk($sformatf("fp.gnt1 k%0d", k), 32'(s_gnt[1][1]), 32'(k == 3 || k == 7));
         chk($sformatf("fp.gnt0 k%0d", k), 32'(s_gnt[1][0]), 32'(!(k == 3 || k == 7)));
      end

      // Byte write from requester 1
      do_reset();
      mem[0][2] = 32'h11223344;
      set_req(0, 1, 2, 32'hAABBCCDD, 4'b0010, 1'b0);
      cycle();
      chk("bw.gnt1", 32'(s_gnt[0][1]), 32'd1);
      chk("bw.gnt0", 32'(s_gnt[0][0]), 32'd0);
      idle();
      cycle();
      chk("bw.ack1", 32'(s_ack[0][1]), 32'd1);
      chk("bw.rdata1", s_rd[0][1], 32'h11223344);
      chk("bw.mem", mem[0][2], 32'h1122CC44);
      cycle();
      chk("bw.ack1 once", 32'(s_ack[0][1]), 32'd0);

      // Reset while a write is presented: no grant, no write, no ack
      mem[0][7] = 32'hCAFEF00D;
      rst = 1'b1;
      set_req(0, 0, 7, 32'h0, 4'hF, 1'b0);
      cycle();
      chk("rst.gnt0", 32'(s_gnt[0][0]), 32'd0);
      chk("rst.dm_we", 32'(s_we[0]), 32'd0);
      rst = 1'b0;
      idle();
      cycle();
      chk("rst.ack0", 32'(s_ack[0][0]), 32'd0);
      chk("rst.mem", mem[0][7], 32'hCAFEF00D);
      // Reset arriving in the ack cycle drops the pending ack
      set_req(0, 0, 8, 32'h0, 4'h0, 1'b0);
      cycle();
      rst = 1'b1;
      idle();
      cycle();
      chk("rst.ack0 pending", 32'(s_ack[0][0]), 32'd0);
      rst = 1'b0;

      // Lock held by requester 1
      do_reset();
      set_req(0, 1, 3, 32'h0, 4'h0, 1'b1);
      cycle();
      set_req(0, 0, 4, 32'h0, 4'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk($sformatf("lock.gnt0 k%0d", k), 32'(s_gnt[0][0]), LOCK_EN ? 32'd0 : 32'(k % 2 == 0));
      end
      i_lock[0][1] = 1'b0;
      cycle();
      chk("lock.gnt0 release", 32'(s_gnt[0][0]), 32'd1);

      // Random traffic on both instances
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int d = 0; d < 2; d++)
            for (int x = 0; x < 2; x++) begin
               if (i_req[d][x]) begin
                  if (win[d] == x) begin
                     if ($urandom_range(0, 3) != 0) rand_req(d, x);
                     else begin
                        i_req[d][x]  = 1'b0;
                        i_lock[d][x] = 1'b0;
                     end
                  end
               end else if ($urandom_range(0, 1) != 0) begin
                  rand_req(d, x);
               end
            end
         rst = ($urandom_range(0, 63) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory.
- Requester 0 is the CPU MEM stage; requester 1 is a secondary master (debug loader or DMA).
- Grants at most one access per cycle and drives the memory's address, write-data, byte-enable and PC inputs.
- Returns registered read data and a one-cycle completion pulse to the winning requester.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate on conflict; 0 = fixed priority to requester 0.
- STARVE_LIMIT, 8, consecutive denied cycles after which the denied requester is forced to win. Range 1..255; 0 disables the forcing.

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- m0_req  in  1  requester 0 access request
- m0_addr  in  30  word address [31:2]
- m0_wdata  in  32  write data
- m0_we  in  4  byte write enables; 0 = read
- m0_pc  in  32  PC of the issuing instruction, forwarded to memory
- m0_lock  in  1  lock request (used only with the macro)
- m0_gnt  out  1  access accepted this cycle (combinational)
- m0_ack  out  1  completion pulse, one cycle after grant
- m0_rdata  out  32  read word, valid while m0_ack is high
- m1_req, m1_addr, m1_wdata, m1_we, m1_pc, m1_lock, m1_gnt, m1_ack, m1_rdata: identical to the m0_* ports, for requester 1
- dm_addr  out  30  to memory Addr[31:2]
- dm_wdata  out  32  to memory WData
- dm_we  out  4  to memory WE
- dm_pc  out  32  to memory PC
- dm_rdata  in  32  memory RData (combinational from dm_addr)

Behaviour:
- Request protocol:
  - An access is accepted in the cycle where mX_req and mX_gnt are both high.
  - While gnt is low, the requester holds req, addr, wdata and we stable.
  - At most one gnt is high per cycle; gnt is never high without the matching req.
- Arbitration, evaluated each cycle:
  - Priority 1: the lock owner (macro only).
  - Priority 2: any requester whose starvation counter has reached STARVE_LIMIT.
  - Priority 3, only one requester active: that requester wins.
  - Priority 4, both requesting with ROUND_ROBIN=1: the requester not in last_gnt wins.
  - Priority 5, both requesting with ROUND_ROBIN=0: requester 0 wins.
- Memory side, combinational mux of the winner:
  - dm_addr, dm_wdata, dm_we and dm_pc carry the winner's signals.
  - dm_we = 0 when there is no winner or reset is high; dm_addr, dm_wdata and dm_pc = 0 when there is no winner.
- Completion, sequential:
  - On a grant, capture dm_rdata into mX_rdata at posedge and set mX_ack = 1 for exactly one cycle.
  - Writes also ack; their rdata is the pre-write word.
  - Back-to-back grants to the same requester give back-to-back acks.
- last_gnt: 1-bit register, updated on every grant. Reset value is 1, so requester 0 wins the first conflict.
- Starvation counters (8-bit, one per requester):
  - Increment when req=1 and gnt=0; saturate at 255.
  - Clear on that requester's grant or when its req drops.
- Reset: m0_gnt and m1_gnt = 0; m0_ack, m1_ack, m0_rdata and m1_rdata = 0; counters = 0; lock owner = none; last_gnt = 1.
- Reset mid-operation: requests presented during reset are neither granted nor acked, and an ack pending from the pre-reset cycle is dropped.
- Simultaneous forcing: if both counters have reached STARVE_LIMIT, requester 0 wins.

Optional Feature:
- Macro: DM_ARB_LOCK_EN.
- With the macro:
  - A grant with mX_lock=1 makes X the lock owner from the next cycle.
  - While the owner keeps lock=1, the other requester is never granted.
  - The other requester's starvation counter still counts but does not override the lock.
  - The lock is released when the owner drops lock or req; the owner's requests keep normal gnt/ack.
- Without the macro: lock inputs are ignored and the lock owner is always none; the ports stay present.

Test Plan:
- Single read: after reset, mem[5]=0x12345678, m0 reads addr 5 → m0_gnt in the same cycle, m0_ack next cycle with m0_rdata=0x12345678, m1 signals stay 0.
- Conflict, ROUND_ROBIN=1, both requesting continuously → grants ordered m0, m1, m0, m1; acks one cycle behind each.
- Fixed priority, starvation: ROUND_ROBIN=0, STARVE_LIMIT=3, both requesting continuously → m0 granted in cycles 0-2, m1 forced in cycle 3, m0 in 4-6, m1 in 7.
- Byte write: m1 write addr 2, wdata 0xAABBCCDD, we=4'b0010 over word 0x11223344 → memory word becomes 0x1122CC44, m1_ack pulses once, m0_gnt=0 that cycle.
- Reset mid-operation: assert reset in the cycle m0 has a granted write pending ack → m0_ack=0 next cycle, dm_we=0 while reset is high, no memory write.
- Lock, DM_ARB_LOCK_EN defined: m1 holds lock=1 and req=1 for 4 cycles while m0 requests → m0_gnt=0 for those cycles, m0 granted the cycle after m1 drops lock. Without the macro, the same stimulus alternates grants.
